motor_enable_ctrl: RTL and testbench
====================================

// Module: motor_enable_ctrl
// PURPOSE
//  Multi-channel stepper-driver enable controller; next generation of the single-motor enable logic.
//  Each channel enables its motor for one of three reasons:
//    - continuous mode (on_switch);
//    - a counted move of N steps;
//    - a post-motion holding-torque interval.
//  A shared fault input forces every motor off.
//  Sits between the switch/command front end and the per-motor step generators and driver enable pins.
// PARAMETERS
//  NUM_CH       2        number of independent motor channels (>=1)
//  STEP_W       16       width of move step count; max move = 2**STEP_W-1 steps
//  HOLD_CYCLES  50000    clk cycles enable is held after motion stops; 0 = no hold phase
// PORTS
//  clk          in   1               system clock, all logic on rising edge
//  rst          in   1               synchronous, active-high reset
//  on_switch    in   NUM_CH          per-channel continuous-motion request (level)
//  move_req     in   NUM_CH          per-channel single-cycle move request
//  move_steps   in   NUM_CH*STEP_W   step count per channel; ch i = [i*STEP_W +: STEP_W]; sampled with move_req
//  step_tick    in   NUM_CH          one-cycle pulse per step issued by that channel's step generator
//  fault        in   1               global fault (level); highest priority
//  motor_enable out  NUM_CH          driver enable, registered
//  move_busy    out  NUM_CH          high while a counted move is in progress
//  move_done    out  NUM_CH          one-cycle pulse on successful completion of a counted move
// BEHAVIOUR
//  - Reset: all channels IDLE, step/hold counters 0, motor_enable=0, move_busy=0, move_done=0.
//  - Per-channel FSM states: IDLE, CONT, MOVE, HOLD. Outputs are registered from next-state:
//      motor_enable = (state != IDLE); move_busy = (state == MOVE).
//    All outputs change in the cycle after the causing input (1-cycle latency).
//  - IDLE/HOLD -> CONT when on_switch=1. on_switch takes priority over a move_req arriving in the same cycle.
//  - IDLE/HOLD -> MOVE on move_req with move_steps != 0; step counter loads move_steps.
//    move_req with move_steps == 0: move_done pulses next cycle, state unchanged.
//  - MOVE: each step_tick decrements the counter. A tick with counter == 1 completes the move:
//      move_done pulses next cycle; next state = CONT if on_switch=1, else HOLD (IDLE if HOLD_CYCLES == 0).
//    on_switch does not abort a move. move_req during MOVE is ignored (no re-load, no queueing).
//  - CONT: move_req ignored; step_tick ignored. on_switch=0 -> HOLD (IDLE if HOLD_CYCLES == 0).
//  - HOLD: hold counter loads HOLD_CYCLES-1 on entry and decrements each cycle; at 0 -> IDLE.
//    Enable therefore stays high for exactly HOLD_CYCLES cycles after leaving MOVE/CONT.
//  - fault=1: every channel -> IDLE on the next edge; active moves aborted with no move_done.
//    While fault is high, on_switch, move_req and step_tick are ignored.
//    After fault falls, a still-high on_switch re-enters CONT on the following edge.
//  - rst mid-move or mid-hold: identical to power-on reset, no move_done.
//  - Channels are fully independent except for the shared fault and rst.
// STRUCTURE
//  - Package motor_enable_pkg: typedef enum logic [1:0] {EN_IDLE, EN_CONT, EN_MOVE, EN_HOLD} en_state_t;
//    hold-counter width function clog2 (HOLD_CYCLES+1).
//  - Sub-module motor_enable_chan: one channel (FSM, STEP_W step counter, hold counter).
//  - Top generates NUM_CH instances and slices move_steps.
// TESTING  (bench HOLD_CYCLES=4, STEP_W=8, NUM_CH=2)
//  1. Reset, then on_switch[0]=1 for 10 cycles, then 0
//     -> motor_enable[0] rises 1 cycle after on_switch, stays high 10 + 4 cycles, then falls; ch1 stays 0.
//  2. move_req[1] with steps=3, then 3 step_ticks spaced 5 cycles apart
//     -> move_busy[1] high until 1 cycle after 3rd tick; move_done[1] single pulse then;
//        enable held 4 more cycles, then 0.
//  3. move_req[0] with steps=0 -> move_done[0] pulse next cycle; motor_enable[0] never rises.
//  4. fault=1 after 2nd tick of a 5-step move on ch0 while ch1 in CONT
//     -> both enables 0 next cycle; no move_done; with on_switch[1] still high,
//        ch1 enables 1 cycle after fault clears.
//  5. move_req and on_switch on the same cycle on ch0 -> CONT, move_busy stays 0.
//     on_switch rising during a move -> move completes with move_done, enable stays high (CONT).
//  6. move_req during MOVE and during CONT -> ignored: step counter unchanged, no extra move_done.
//     rst during HOLD -> all outputs 0 next cycle.

Source files
------------

// File: rtl/motor_enable_pkg.sv
// Shared types and helpers for the multi-channel motor enable controller.
package motor_enable_pkg;

  typedef enum logic [1:0] {
    EN_IDLE,
    EN_CONT,
    EN_MOVE,
    EN_HOLD
  } en_state_t;

  // Hold counter width: enough bits to hold HOLD_CYCLES, never narrower than 1.
  function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
    int unsigned w;
    w = $clog2(hold_cycles + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/motor_enable_chan.sv
// One motor channel: enable FSM with counted-move step counter and
// post-motion holding-torque counter.
module motor_enable_chan
  import motor_enable_pkg::*;
#(
  parameter int unsigned STEP_W      = 16,
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              on_switch_i,
  input  logic              move_req_i,
  input  logic [STEP_W-1:0] move_steps_i,
  input  logic              step_tick_i,
  input  logic              fault_i,
  output logic              motor_enable_o,
  output logic              move_busy_o,
  output logic              move_done_o
);

  localparam int unsigned HOLD_W = hold_cnt_w(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  // With no hold phase, motion stop goes straight back to idle.
  localparam en_state_t POST_STATE = (HOLD_CYCLES > 0) ? EN_HOLD : EN_IDLE;

  en_state_t         state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_d;
  logic              motor_enable_q, move_busy_q, move_done_q;

  // Next-state, counter and done-pulse logic; fault overrides everything.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (fault_i) begin
      state_d = EN_IDLE;
      step_d  = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        EN_IDLE, EN_HOLD: begin
          if (on_switch_i) begin
            state_d = EN_CONT;
            hold_d  = '0;
          end else if (move_req_i && (move_steps_i != '0)) begin
            state_d = EN_MOVE;
            step_d  = move_steps_i;
            hold_d  = '0;
          end else begin
            // A zero-length move completes immediately without leaving the state.
            if (move_req_i) done_d = 1'b1;
            if (state_q == EN_HOLD) begin
              if (hold_q == '0) state_d = EN_IDLE;
              else              hold_d  = hold_q - 1'b1;
            end
          end
        end
        EN_MOVE: begin
          if (step_tick_i) begin
            if (step_q == STEP_W'(1)) begin
              done_d = 1'b1;
              step_d = '0;
              if (on_switch_i) begin
                state_d = EN_CONT;
              end else begin
                state_d = POST_STATE;
                hold_d  = HOLD_LOAD;
              end
            end else begin
              step_d = step_q - 1'b1;
            end
          end
        end
        EN_CONT: begin
          if (!on_switch_i) begin
            state_d = POST_STATE;
            hold_d  = HOLD_LOAD;
          end
        end
        default: state_d = EN_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= EN_IDLE;
      step_q         <= '0;
      hold_q         <= '0;
      motor_enable_q <= 1'b0;
      move_busy_q    <= 1'b0;
      move_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      hold_q         <= hold_d;
      motor_enable_q <= (state_d != EN_IDLE);
      move_busy_q    <= (state_d == EN_MOVE);
      move_done_q    <= done_d;
    end
  end

  assign motor_enable_o = motor_enable_q;
  assign move_busy_o    = move_busy_q;
  assign move_done_o    = move_done_q;

endmodule

// File: rtl/motor_enable_ctrl.sv
// Multi-channel stepper-driver enable controller: independent channels
// sharing clock, reset and a global fault.
module motor_enable_ctrl
  import motor_enable_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned STEP_W      = 16,
  parameter int unsigned HOLD_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        on_switch,
  input  logic [NUM_CH-1:0]        move_req,
  input  logic [NUM_CH*STEP_W-1:0] move_steps,
  input  logic [NUM_CH-1:0]        step_tick,
  input  logic                     fault,
  output logic [NUM_CH-1:0]        motor_enable,
  output logic [NUM_CH-1:0]        move_busy,
  output logic [NUM_CH-1:0]        move_done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    motor_enable_chan #(
      .STEP_W      (STEP_W),
      .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan (
      .clk_i          (clk),
      .rst_i          (rst),
      .on_switch_i    (on_switch[i]),
      .move_req_i     (move_req[i]),
      .move_steps_i   (move_steps[i*STEP_W +: STEP_W]),
      .step_tick_i    (step_tick[i]),
      .fault_i        (fault),
      .motor_enable_o (motor_enable[i]),
      .move_busy_o    (move_busy[i]),
      .move_done_o    (move_done[i])
    );
  end

endmodule

// File: tb/tb_motor_enable_ctrl.sv
// Bench for motor_enable_ctrl: directed scenarios plus random stimulus,
// all checked against a counter-based behavioural model.
module tb_motor_enable_ctrl;

  localparam int NUM_CH      = 2;
  localparam int STEP_W      = 8;
  localparam int HOLD_CYCLES = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        on_switch, move_req, step_tick;
  logic [NUM_CH*STEP_W-1:0] move_steps;
  logic                     fault;
  logic [NUM_CH-1:0]        motor_enable, move_busy, move_done;

  int total = 0;
  int bad   = 0;

  motor_enable_ctrl #(
    .NUM_CH      (NUM_CH),
    .STEP_W      (STEP_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .on_switch    (on_switch),
    .move_req     (move_req),
    .move_steps   (move_steps),
    .step_tick    (step_tick),
    .fault        (fault),
    .motor_enable (motor_enable),
    .move_busy    (move_busy),
    .move_done    (move_done)
  );

  always #5 clk = ~clk;

  // Reference model: remaining steps, continuous flag, hold cycles left.
  int               m_rem  [NUM_CH] = '{default: 0};
  int               m_hold [NUM_CH] = '{default: 0};
  bit               m_cont [NUM_CH] = '{default: 1'b0};
  logic [NUM_CH-1:0] exp_en   = '0;
  logic [NUM_CH-1:0] exp_busy = '0;
  logic [NUM_CH-1:0] exp_done = '0;

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      int r, h, stp;
      bit cn, dn;
      r = m_rem[c]; h = m_hold[c]; cn = m_cont[c]; dn = 1'b0;
      stp = int'(move_steps[c*STEP_W +: STEP_W]);
      if (rst || fault) begin
        r = 0; h = 0; cn = 1'b0;
      end else if (r > 0) begin
        if (step_tick[c]) begin
          if (r == 1) begin
            r = 0; dn = 1'b1;
            if (on_switch[c]) cn = 1'b1; else h = HOLD_CYCLES;
          end else r = r - 1;
        end
      end else if (cn) begin
        if (!on_switch[c]) begin cn = 1'b0; h = HOLD_CYCLES; end
      end else begin
        if (on_switch[c]) begin
          cn = 1'b1; h = 0;
        end else begin
          if (move_req[c] && stp == 0) dn = 1'b1;
          if (move_req[c] && stp != 0) begin r = stp; h = 0; end
          else if (h > 0) h = h - 1;
        end
      end
      m_rem[c]    <= r;
      m_hold[c]   <= h;
      m_cont[c]   <= cn;
      exp_en[c]   <= (r > 0) || cn || (h > 0);
      exp_busy[c] <= (r > 0);
      exp_done[c] <= dn;
    end
  end

  task automatic clear_inputs();
    on_switch = '0; move_req = '0; step_tick = '0; move_steps = '0; fault = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; on_switch = '1; move_req = '1; step_tick = '1;
    move_steps = '1; fault = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({motor_enable, move_busy, move_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset got=%b exp=%b", {motor_enable, move_busy, move_done}, 6'b0);
    end
    rst = 1'b0; clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_cont();
    int en0 = 0, en1 = 0;
    on_switch = 2'b01;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL cont_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (j == 0) begin
        total++;
        if (motor_enable[0] !== 1'b1) begin bad++; $display("FAIL cont_rise got=%b exp=1", motor_enable[0]); end
      end
      if (motor_enable[0]) en0++;
      if (motor_enable[1]) en1++;
      if (j == 9) on_switch = 2'b00;
    end
    total++;
    if (en0 != 14) begin bad++; $display("FAIL cont_en_cycles got=%0d exp=14", en0); end
    total++;
    if (en1 != 0) begin bad++; $display("FAIL cont_ch1_quiet got=%0d exp=0", en1); end
  endtask

  task automatic test_move();
    int busy_n = 0, done_n = 0, en_n = 0, done_at = -1;
    move_req = 2'b10; move_steps = {8'd3, 8'd0};
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL move_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (move_busy[1]) busy_n++;
      if (motor_enable[1]) en_n++;
      if (move_done[1]) begin done_n++; done_at = j; end
      move_req = '0; step_tick = '0;
      if (j == 4 || j == 9 || j == 14) step_tick = 2'b10;
    end
    total++;
    if (busy_n != 15) begin bad++; $display("FAIL move_busy_cycles got=%0d exp=15", busy_n); end
    total++;
    if (done_n != 1 || done_at != 15) begin
      bad++; $display("FAIL move_done got=%0d@%0d exp=1@15", done_n, done_at);
    end
    total++;
    if (en_n != 19) begin bad++; $display("FAIL move_en_cycles got=%0d exp=19", en_n); end
  endtask

  task automatic test_zero_move();
    int done_n = 0, en_n = 0, done_at = -1;
    move_req = 2'b01; move_steps = '0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL zero_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (move_done[0]) begin done_n++; done_at = j; end
      if (motor_enable[0]) en_n++;
      move_req = '0;
    end
    total++;
    if (done_n != 1 || done_at != 0) begin
      bad++; $display("FAIL zero_done got=%0d@%0d exp=1@0", done_n, done_at);
    end
    total++;
    if (en_n != 0) begin bad++; $display("FAIL zero_en got=%0d exp=0", en_n); end
  endtask

  task automatic test_fault();
    int done_n = 0;
    on_switch = 2'b10; move_req = 2'b01; move_steps = {8'd0, 8'd5};
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL fault_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (j == 7) begin
        total++;
        if (motor_enable !== 2'b00) begin bad++; $display("FAIL fault_off got=%b exp=00", motor_enable); end
      end
      if (j == 8) begin
        total++;
        if (motor_enable[1] !== 1'b0) begin bad++; $display("FAIL fault_hold_off got=%b exp=0", motor_enable[1]); end
      end
      if (j == 9) begin
        total++;
        if (motor_enable !== 2'b10) begin bad++; $display("FAIL fault_recover got=%b exp=10", motor_enable); end
      end
      if (move_done[0]) done_n++;
      move_req = '0; step_tick = '0;
      if (j == 2 || j == 4) step_tick = 2'b01;
      if (j == 6) fault = 1'b1;
      if (j == 7) begin move_req = 2'b01; move_steps = {8'd0, 8'd7}; step_tick = 2'b11; end
      if (j == 8) fault = 1'b0;
      if (j == 15) on_switch = 2'b00;
    end
    total++;
    if (done_n != 0) begin bad++; $display("FAIL fault_no_done got=%0d exp=0", done_n); end
  endtask

  task automatic test_priority();
    int busy_n = 0, done_n = 0, done_at = -1;
    move_req = 2'b01; on_switch = 2'b01; move_steps = {8'd0, 8'd6};
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL prio_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (j == 0) begin
        total++;
        if ({motor_enable[0], move_busy[0]} !== 2'b10) begin
          bad++; $display("FAIL prio_cont got=%b exp=10", {motor_enable[0], move_busy[0]});
        end
      end
      if (j == 16) begin
        total++;
        if ({motor_enable[0], move_busy[0]} !== 2'b10) begin
          bad++; $display("FAIL prio_move_to_cont got=%b exp=10", {motor_enable[0], move_busy[0]});
        end
      end
      if (move_busy[0]) busy_n++;
      if (move_done[0]) begin done_n++; done_at = j; end
      move_req = '0; step_tick = '0;
      if (j == 2) on_switch = 2'b00;
      if (j == 10) begin move_req = 2'b01; move_steps = {8'd0, 8'd2}; end
      if (j == 12 || j == 14) step_tick = 2'b01;
      if (j == 13) on_switch = 2'b01;
      if (j == 20) on_switch = 2'b00;
    end
    total++;
    if (busy_n != 4) begin bad++; $display("FAIL prio_busy_cycles got=%0d exp=4", busy_n); end
    total++;
    if (done_n != 1 || done_at != 15) begin
      bad++; $display("FAIL prio_done got=%0d@%0d exp=1@15", done_n, done_at);
    end
  endtask

  task automatic test_ignore_and_rst();
    int busy_n = 0, late_busy = 0, done_n = 0, done_at = -1;
    move_req = 2'b01; move_steps = {8'd0, 8'd4};
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL ign_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      if (j == 19) begin
        total++;
        if (motor_enable[0] !== 1'b1) begin bad++; $display("FAIL ign_hold_en got=%b exp=1", motor_enable[0]); end
      end
      if (j == 20) begin
        total++;
        if ({motor_enable, move_busy, move_done} !== 6'b0) begin
          bad++; $display("FAIL rst_in_hold got=%b exp=%b", {motor_enable, move_busy, move_done}, 6'b0);
        end
      end
      if (move_busy[0]) begin if (j < 11) busy_n++; else late_busy++; end
      if (move_done[0]) begin done_n++; done_at = j; end
      move_req = '0; step_tick = '0; rst = 1'b0;
      if (j == 1 || j == 5 || j == 7 || j == 9 || j == 15) step_tick = 2'b01;
      if (j == 3) begin move_req = 2'b01; move_steps = {8'd0, 8'd9}; end
      if (j == 12) on_switch = 2'b01;
      if (j == 14) begin move_req = 2'b01; move_steps = {8'd0, 8'd3}; end
      if (j == 17) on_switch = 2'b00;
      if (j == 19) rst = 1'b1;
    end
    total++;
    if (busy_n != 10) begin bad++; $display("FAIL ign_busy_cycles got=%0d exp=10", busy_n); end
    total++;
    if (done_n != 1 || done_at != 10) begin
      bad++; $display("FAIL ign_done got=%0d@%0d exp=1@10", done_n, done_at);
    end
    total++;
    if (late_busy != 0) begin bad++; $display("FAIL ign_cont_req got=%0d exp=0", late_busy); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 1500; j++) begin
      @(negedge clk);
      total++;
      if ({motor_enable, move_busy, move_done} !== {exp_en, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL rand_model t=%0t got=%b exp=%b", $time, {motor_enable, move_busy, move_done}, {exp_en, exp_busy, exp_done});
      end
      rst   = ($urandom_range(0, 199) == 0);
      fault = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 19) == 0) on_switch[c] = ~on_switch[c];
        move_req[c]  = ($urandom_range(0, 9) == 0);
        step_tick[c] = ($urandom_range(0, 2) == 0);
        move_steps[c*STEP_W +: STEP_W] = STEP_W'($urandom_range(0, 6));
      end
    end
    rst = 1'b0; clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_cont();
    test_move();
    test_zero_move();
    test_fault();
    test_priority();
    test_ignore_and_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
